// File: rtl/mux2.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : mux2
//  Description : Two-input, one-output data selector with a single select
//                line. The selected word is registered on clk by default
//                (one-cycle latency, glitch-free output); setting OUT_REG
//                to 0 turns the block into a purely combinational selector.
//
//  Parameters  : WIDTH      - bit width of a, b and out
//                OUT_REG    - 1: registered output, 0: combinational output
//                RESET_VAL  - value forced onto out while rst is high
//                             (zero-extended / truncated to WIDTH bits)
//
//  Ports       : clk  in   1      system clock, rising-edge active
//                rst  in   1      asynchronous, active-high reset
//                a    in   WIDTH  data selected when sl = 0
//                b    in   WIDTH  data selected when sl = 1
//                sl   in   1      select: 0 -> a, 1 -> b
//                out  out  WIDTH  selected data
//
//  Revision    : 1.0  initial release
// ============================================================================
module mux2 #(
    parameter int          WIDTH     = 1,
    parameter int          OUT_REG   = 1,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sl,
    output logic [WIDTH-1:0] out
);

    // Reset value sized to the data path; the cast zero-extends or truncates.
    localparam logic [WIDTH-1:0] c_RESET_VAL = WIDTH'(RESET_VAL);

    // Selected word. An X/Z select propagates X by ordinary ternary rules;
    // no masking is attempted.
    logic [WIDTH-1:0] w_sel_data;
    assign w_sel_data = sl ? b : a;

    generate
        if (OUT_REG != 0) begin : g_reg
            // Single output register loaded every cycle. Because a, b and sl
            // are all sampled on the same edge, old select can never pair
            // with new data, and sl activity between edges never reaches out.
            logic [WIDTH-1:0] r_out;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_out <= c_RESET_VAL;
                end else begin
                    r_out <= w_sel_data;
                end
            end

            assign out = r_out;
        end else begin : g_comb
            // Zero-latency path; clock and reset play no part here.
            logic w_unused_clk_rst;
            assign w_unused_clk_rst = clk ^ rst;

            assign out = w_sel_data;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_mux2.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_mux2
//  Description : Self-checking bench for mux2. Three instances share a clock
//                and reset: registered 1-bit (defaults), registered 8-bit
//                with a non-zero reset value, and combinational 8-bit.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mux2;

    localparam logic [7:0] c_RV8 = 8'hC3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;

    logic [0:0] a1  = '0;
    logic [0:0] b1  = '0;
    logic       sl1 = 1'b0;
    logic [0:0] out1;

    logic [7:0] a8  = '0;
    logic [7:0] b8  = '0;
    logic       sl8 = 1'b0;
    logic [7:0] out8;
    logic [7:0] outc;

    int n_checks = 0;
    int n_fail   = 0;

    // Values the registered instances must show after the next rising edge.
    logic [7:0] pend1 = '0;
    logic [7:0] pend8 = '0;

    always #2.5 clk = ~clk;

    mux2 u_reg1 (
        .clk (clk),
        .rst (rst),
        .a   (a1),
        .b   (b1),
        .sl  (sl1),
        .out (out1)
    );

    mux2 #(
        .WIDTH     (8),
        .OUT_REG   (1),
        .RESET_VAL (32'hC3)
    ) u_reg8 (
        .clk (clk),
        .rst (rst),
        .a   (a8),
        .b   (b8),
        .sl  (sl8),
        .out (out8)
    );

    mux2 #(
        .WIDTH     (8),
        .OUT_REG   (0),
        .RESET_VAL (0)
    ) u_comb (
        .clk (clk),
        .rst (rst),
        .a   (a8),
        .b   (b8),
        .sl  (sl8),
        .out (outc)
    );

    // Reference selector: the two sources form a table indexed by select.
    function automatic logic [7:0] pick(input logic s, input logic [7:0] x,
                                        input logic [7:0] y);
        logic [7:0] src [2];
        src[0] = x;
        src[1] = y;
        return src[s];
    endfunction

    task automatic check(input string tag, input logic [7:0] obs,
                         input logic [7:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Called just after a rising edge with new inputs already applied:
    // checks the combinational instance, records what the registered
    // instances should capture, then checks them one edge later.
    task automatic step(input string tag);
        #0.5;
        check({tag, "_comb"}, outc, pick(sl8, a8, b8));
        pend1 = pick(sl1, 8'(a1), 8'(b1));
        pend8 = pick(sl8, a8, b8);
        @(posedge clk);
        #1;
        check({tag, "_reg1"}, 8'(out1), pend1);
        check({tag, "_reg8"}, out8, pend8);
    endtask

    initial begin
        // ---------------- asynchronous reset ----------------
        #1;
        a1 = 1'b1; b1 = 1'b0; sl1 = 1'b0;
        a8 = 8'h5A; b8 = 8'hA5; sl8 = 1'b0;
        rst = 1'b1;
        #0.5;                                   // before the first clk edge
        check("rst_async_reg1", 8'(out1), 8'h00);
        check("rst_async_reg8", out8, c_RV8);
        check("rst_comb_sl0", outc, 8'h5A);
        sl8 = 1'b1;
        #0.5;
        check("rst_comb_sl1", outc, 8'hA5);
        sl8 = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("rst_hold_reg1", 8'(out1), 8'h00);
            check("rst_hold_reg8", out8, c_RV8);
        end
        rst = 1'b0;
        #0.5;
        check("rst_release_noedge", 8'(out1), 8'h00);
        step("rst_release");                    // first edge loads a = 1

        // ---------------- select a: a every 10 ns, b every 20 ns ----------------
        sl1 = 1'b0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            a1  = 1'((cyc >> 1) & 1);
            b1  = 1'((cyc >> 2) & 1);
            a8  = 8'($urandom);
            b8  = 8'($urandom);
            sl8 = 1'b0;
            step("sel_a");
        end

        // ---------------- select b ----------------
        sl1 = 1'b1;
        for (int cyc = 0; cyc < 16; cyc++) begin
            a1  = 1'((cyc >> 1) & 1);
            b1  = 1'((cyc >> 2) & 1);
            a8  = 8'($urandom);
            b8  = 8'($urandom);
            sl8 = 1'b1;
            step("sel_b");
        end

        // ---------------- select switch at 1000 ns ----------------
        sl1 = 1'b0; a1 = 1'b0; b1 = 1'b1;
        for (int k = 0; k < 400 && $realtime < 995.0; k++) begin
            step("pre_switch");
        end
        check("pre_switch_out", 8'(out1), 8'h00);
        #(1000.0 - $realtime);
        sl1 = 1'b1;                              // flip between edges
        #0.5;
        check("switch_noglitch_a", 8'(out1), 8'h00);
        sl1 = 1'b0;
        #0.5;
        check("switch_noglitch_b", 8'(out1), 8'h00);
        sl1 = 1'b1;
        pend1 = pick(sl1, 8'(a1), 8'(b1));
        @(posedge clk);
        #1;
        check("switch_edge", 8'(out1), pend1);
        check("switch_edge_reg8", out8, pend8);

        // ---------------- reset mid-stream ----------------
        sl1 = 1'b1; b1 = 1'b1; a1 = 1'b0;
        sl8 = 1'b1; b8 = 8'h96; a8 = 8'h11;
        repeat (3) step("stream_b");
        rst = 1'b1;                              // 3 ns pulse between edges
        #0.5;
        check("midrst_reg1", 8'(out1), 8'h00);
        check("midrst_reg8", out8, c_RV8);
        check("midrst_comb", outc, 8'h96);
        #2.5;
        rst = 1'b0;
        #0.5;
        check("midrst_after_reg1", 8'(out1), 8'h00);
        check("midrst_after_reg8", out8, c_RV8);
        @(posedge clk);
        #1;
        check("midrst_resume_reg1", 8'(out1), 8'h01);
        check("midrst_resume_reg8", out8, 8'h96);

        // ---------------- fixed combinational pattern ----------------
        a8 = 8'h5A; b8 = 8'hA5; sl8 = 1'b0;
        step("pat_5a");
        sl8 = 1'b1;
        step("pat_a5");

        // ---------------- randomized burst ----------------
        for (int k = 0; k < 40; k++) begin
            a1  = 1'($urandom);
            b1  = 1'($urandom);
            sl1 = 1'($urandom);
            a8  = 8'($urandom);
            b8  = 8'($urandom);
            sl8 = 1'($urandom);
            step("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
